// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared decode constants and status packing for mem_io_responder
package mem_io_pkg;

  localparam logic [31:0] IO_BASE   = 32'h0003_0000;
  localparam int          IO_SEL_HI = 17;
  localparam int          IO_SEL_LO = 16;

  localparam logic [2:0] IO_OFF_DATA = 3'd0;
  localparam logic [2:0] IO_OFF_STAT = 3'd4;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_OVF      = 2;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full, input logic rxv);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_RX_VALID] = rxv;
    s[STAT_TX_FULL]  = full;
    s[STAT_OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - circular byte FIFO; a push while full is accepted only alongside a pop
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so nothing stale leaks out after reset.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM plus TX/RX/status IO window behind the CPU memory bus
module mem_io_responder #(
  parameter int          ADDR_WIDTH    = 17,
  parameter int          TX_DEPTH_LOG2 = 3,
  parameter logic [31:0] IO_BASE       = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_w_data,
  output logic [7:0]  mem_r_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        io_overflow
);

  import mem_io_pkg::*;

  localparam int RAM_SIZE = 1 << ADDR_WIDTH;

  logic [7:0]            ram [RAM_SIZE];
  logic [ADDR_WIDTH-1:0] idx;
  logic [2:0]            off;
  logic                  io_sel;
  logic                  bus_rd;
  logic                  bus_wr;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  stat_clear;
  logic [7:0]            rd_next;
  logic                  unused_addr;

  assign idx         = mem_addr[ADDR_WIDTH-1:0];
  assign off         = mem_addr[2:0];
  assign io_sel      = (mem_addr[IO_SEL_HI:IO_SEL_LO] == IO_BASE[IO_SEL_HI:IO_SEL_LO]);
  assign bus_rd      = rdy_in && !mem_wr;
  assign bus_wr      = rdy_in && mem_wr;
  assign unused_addr = ^mem_addr;

  assign tx_push    = bus_wr && io_sel && (off == IO_OFF_DATA);
  assign stat_clear = bus_wr && io_sel && (off == IO_OFF_STAT) && mem_w_data[STAT_OVF];
  // TX drain runs regardless of rdy_in; only the bus side is frozen.
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_valid   = !tx_empty;
  assign rx_pop     = rst_n_in && bus_rd && io_sel && (off == IO_OFF_DATA) && rx_valid;

  always_comb begin
    rd_next = 8'h00;
    if (!io_sel) begin
      rd_next = ram[idx];
    end else if (off == IO_OFF_DATA) begin
      rd_next = rx_valid ? rx_data : 8'h00;
    end else if (off == IO_OFF_STAT) begin
      rd_next = status_byte(io_overflow, tx_full, rx_valid);
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus_wr && !io_sel) ram[idx] <= mem_w_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_r_data  <= 8'h00;
      io_overflow <= 1'b0;
    end else begin
      if (bus_rd) mem_r_data <= rd_next;
      if (stat_clear)
        io_overflow <= 1'b0;
      else if (tx_push && tx_full && !tx_pop)
        io_overflow <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (tx_push),
    .push_data (mem_w_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_data)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - table-driven bench for mem_io_responder
module tb_mem_io_responder;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_r_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        io_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  mem_io_responder dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_w_data  (mem_w_data),
    .mem_r_data  (mem_r_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_pop      (rx_pop),
    .io_overflow (io_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        txr;
    logic        rxv;
    logic [7:0]  rxd;
    logic        pop;
    logic [7:0]  rdata;
    logic        txv;
    logic [7:0]  txd;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rdy, input logic wr, input logic [31:0] addr,
                     input logic [7:0] wdata, input logic txr, input logic rxv,
                     input logic [7:0] rxd, input logic pop, input logic [7:0] rdata,
                     input logic txv, input logic [7:0] txd, input logic ovf);
    vec_t v;
    v.rdy = rdy;   v.wr = wr;     v.addr = addr;   v.wdata = wdata;
    v.txr = txr;   v.rxv = rxv;   v.rxd = rxd;     v.pop = pop;
    v.rdata = rdata; v.txv = txv; v.txd = txd;     v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic wr, input logic [31:0] addr,
                       input logic [7:0] wdata, input logic txr, input logic rxv,
                       input logic [7:0] rxd);
    rdy_in = rdy; mem_wr = wr; mem_addr = addr; mem_w_data = wdata;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h3_0000, 8'h00, 1'b0, 1'b1, 8'h55);
    rst_n_in = 1'b0;
    #12;
    check("reset mem_r_data", {24'h0, mem_r_data}, 32'h0);
    check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset tx_data", {24'h0, tx_data}, 32'h0);
    check("reset rx_pop", {31'h0, rx_pop}, 32'h0);
    check("reset io_overflow", {31'h0, io_overflow}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in) #1;

    // RAM write/read, back-to-back, aliasing and an unmapped IO offset
    row(1, 1, 32'h0_0010, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    row(1, 0, 32'h0_0010, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0);
    row(1, 1, 32'h1_FFFF, 8'h5A, 0, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0);
    row(1, 0, 32'h1_FFFF, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 8'h00, 0);
    row(1, 0, 32'h3_FFFF, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    row(1, 0, 32'h2_0010, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0);
    // Nine TX pushes with the sink stalled: the ninth overflows
    for (int k = 1; k <= 9; k++)
      row(1, 1, 32'h3_0000, 8'(k), 0, 0, 8'h00, 0, 8'hA5, 1, 8'h01, k == 9);
    row(1, 0, 32'h3_0004, 8'h00, 0, 0, 8'h00, 0, 8'h06, 1, 8'h01, 1);
    // Drain with the bus frozen; a frozen status write must not clear overflow
    for (int k = 1; k <= 8; k++)
      row(0, k == 4, (k == 4) ? 32'h3_0004 : 32'h0_0010, (k == 4) ? 8'h04 : 8'h00,
          1, 0, 8'h00, 0, 8'h06, k < 8, (k < 8) ? 8'(k + 1) : 8'h00, 1);
    row(1, 1, 32'h3_0004, 8'h04, 0, 0, 8'h00, 0, 8'h06, 0, 8'h00, 0);
    row(1, 0, 32'h3_0004, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    // RX port with and without a byte available
    row(1, 0, 32'h3_0000, 8'h00, 0, 1, 8'h3C, 1, 8'h3C, 0, 8'h00, 0);
    row(1, 0, 32'h3_0000, 8'h00, 0, 0, 8'h3C, 0, 8'h00, 0, 8'h00, 0);
    // Full FIFO: a push alongside a pop is accepted
    for (int k = 0; k < 8; k++)
      row(1, 1, 32'h3_0000, 8'(8'h11 + k), 0, 0, 8'h00, 0, 8'h00, 1, 8'h11, 0);
    row(1, 1, 32'h3_0000, 8'h77, 1, 0, 8'h00, 0, 8'h00, 1, 8'h12, 0);
    row(1, 0, 32'h3_0004, 8'h00, 0, 0, 8'h00, 0, 8'h02, 1, 8'h12, 0);
    for (int k = 1; k <= 8; k++)
      row(0, 0, 32'h0_0010, 8'h00, 1, 0, 8'h00, 0, 8'h02, k < 8,
          (k <= 6) ? 8'(8'h12 + k) : ((k == 7) ? 8'h77 : 8'h00), 0);
    // rdy_in low freezes RAM writes, reads and RX pops
    row(1, 1, 32'h0_0020, 8'h11, 0, 0, 8'h00, 0, 8'h02, 0, 8'h00, 0);
    row(1, 0, 32'h0_0020, 8'h00, 0, 0, 8'h00, 0, 8'h11, 0, 8'h00, 0);
    row(0, 1, 32'h0_0020, 8'hFF, 0, 0, 8'h00, 0, 8'h11, 0, 8'h00, 0);
    row(0, 0, 32'h3_0000, 8'h00, 0, 1, 8'h99, 0, 8'h11, 0, 8'h00, 0);
    row(1, 0, 32'h0_0020, 8'h00, 0, 0, 8'h00, 0, 8'h11, 0, 8'h00, 0);
    row(1, 0, 32'h0_0010, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].txr, vecs[i].rxv, vecs[i].rxd);
      #1;
      check($sformatf("v%0d rx_pop", i), {31'h0, rx_pop}, {31'h0, vecs[i].pop});
      @(posedge clk_in) #1;
      check($sformatf("v%0d mem_r_data", i), {24'h0, mem_r_data}, {24'h0, vecs[i].rdata});
      check($sformatf("v%0d tx_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].txv});
      check($sformatf("v%0d tx_data", i), {24'h0, tx_data}, {24'h0, vecs[i].txd});
      check($sformatf("v%0d io_overflow", i), {31'h0, io_overflow}, {31'h0, vecs[i].ovf});
    end

    // Asynchronous reset in the middle of a drain
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b1, 32'h3_0000, 8'(8'hC0 + k), 1'b0, 1'b0, 8'h00);
      @(posedge clk_in) #1;
    end
    drive(1'b1, 1'b0, 32'h0_0010, 8'h00, 1'b1, 1'b1, 8'h42);
    @(posedge clk_in) #1;
    check("pre-reset tx_data", {24'h0, tx_data}, 32'hC1);
    check("pre-reset io_overflow", {31'h0, io_overflow}, 32'h1);
    drive(1'b1, 1'b0, 32'h3_0000, 8'h00, 1'b1, 1'b1, 8'h42);
    #2 rst_n_in = 1'b0;
    #1;
    check("mid reset tx_valid", {31'h0, tx_valid}, 32'h0);
    check("mid reset tx_data", {24'h0, tx_data}, 32'h0);
    check("mid reset mem_r_data", {24'h0, mem_r_data}, 32'h0);
    check("mid reset io_overflow", {31'h0, io_overflow}, 32'h0);
    check("mid reset rx_pop", {31'h0, rx_pop}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in) #1;
    check("post reset tx_valid", {31'h0, tx_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the byte-wide CPU memory bus that the memory controller drives (mem_wr, mem_addr, mem_w_data, mem_r_data).
- Serves one byte per cycle from an internal byte RAM, with fixed 1-cycle read latency.
- Maps a small IO window: a serial TX byte FIFO, an RX byte port and a status register.
- Sits below the memory controller at the top level, in place of the external RAM/IO chip.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width; RAM size is 2^ADDR_WIDTH bytes.
TX_DEPTH_LOG2, 3, log2 of the TX FIFO depth (8 entries).
IO_BASE, 32'h0003_0000, base of the IO window; IO is selected when mem_addr[17:16]==2'b11.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low = bus frozen
mem_wr  input  1  1 = write, 0 = read
mem_addr  input  32  byte address
mem_w_data  input  8  write byte
mem_r_data  output  8  read byte, registered
tx_valid  output  1  TX FIFO head is valid
tx_data  output  8  TX FIFO head byte
tx_ready  input  1  sink accepts the head byte this cycle
rx_valid  input  1  RX byte available
rx_data  input  8  RX byte
rx_pop  output  1  1-cycle pulse: RX byte consumed
io_overflow  output  1  sticky: a TX write was dropped

Behaviour:
- Reset (rst_n_in low, asynchronous): mem_r_data=0, tx_valid=0, tx_data=0, rx_pop=0, io_overflow=0, FIFO pointers and count=0. RAM contents are not reset.
- Decode, evaluated each rdy_in-high cycle: io_sel = (mem_addr[17:16]==2'b11). RAM index = mem_addr[ADDR_WIDTH-1:0]. Upper address bits above ADDR_WIDTH are ignored, so the RAM aliases.
- RAM write: mem_wr=1 and !io_sel, so ram[idx] <= mem_w_data at the edge. mem_r_data holds its previous value.
- RAM read: mem_wr=0 and !io_sel. The address presented in cycle N gives mem_r_data = ram[idx] after edge N; the initiator samples it in cycle N+1.
- Read-after-write to the same address in consecutive cycles returns the new byte.
- IO registers (offset = mem_addr[2:0]):
  - Offset 0, write: push mem_w_data into the TX FIFO. If the FIFO is full and not popping this cycle, drop the byte and set io_overflow.
  - Offset 0, read: if rx_valid, mem_r_data <= rx_data and rx_pop pulses for exactly that cycle. Otherwise mem_r_data <= 0 and there is no pop.
  - Offset 4, read: mem_r_data <= {5'b0, io_overflow, tx_full, rx_valid}.
  - Offset 4, write: if mem_w_data[2]=1, clear io_overflow. Other bits are ignored.
  - Other offsets: reads return 0; writes are ignored.
- TX FIFO:
  - Circular buffer; pointers wrap modulo depth; count runs 0..2^TX_DEPTH_LOG2.
  - tx_valid = (count!=0); tx_data = buf[rd_ptr].
  - Pop occurs when tx_valid && tx_ready.
  - Simultaneous push and pop: both happen and the count is unchanged. When full, a push with a same-cycle pop is accepted, not dropped.
  - Push into an empty FIFO: tx_valid rises the next cycle. There is no bypass.
- rdy_in low:
  - No RAM or IO writes, no rx_pop, mem_r_data holds.
  - A write to offset 4 does not clear io_overflow.
  - TX drain to the sink continues, since it is independent of rdy_in.
- No bus handshake: every rdy_in-high cycle is one transaction. Latency is fixed at 1 cycle for both RAM and IO.
- Reset mid-operation: the FIFO empties and tx_valid drops immediately, asynchronously. A byte handed over in that cycle is lost.

Decomposition:
- Package mem_io_pkg holds:
  - IO_BASE and the IO select bits.
  - Offsets IO_OFF_DATA=0 and IO_OFF_STAT=4.
  - Status bit positions STAT_RX_VALID=0, STAT_TX_FULL=1, STAT_OVF=2.
- Sub-module byte_fifo (parameter DEPTH_LOG2) with push/pop/full/empty/head, used for TX.
- RAM is an inferred array inside mem_io_responder.

Test Plan:
- Reset, then write 0xA5 to 0x00010, then read 0x00010: mem_r_data = 0xA5 one cycle after the read address. All outputs are 0 during reset.
- Back-to-back write 0x5A to 0x1FFFF then read 0x1FFFF: returns 0x5A. Read of 0x3FFFF (aliased, IO window, offset 7) returns 0.
- With tx_ready=0, write 0x30000 nine times (0x01..0x09): status read gives 8'h06 (ovf=1, full=1). After setting tx_ready=1, tx_data drains 0x01..0x08 in order. Writing 0x04 to 0x30004 clears the status back to 0.
- rx_valid=1, rx_data=0x3C, read 0x30000: mem_r_data=0x3C and a 1-cycle rx_pop. With rx_valid=0 the same read returns 0x00 and there is no pop.
- With the FIFO full and tx_ready=1, write 0x77 to 0x30000: no overflow, count stays 8, 0x77 is last out.
- Hold rdy_in=0 while driving write 0xFF to 0x00020: ram[0x20] is unchanged (read returns its old value) and mem_r_data holds. Asserting rst_n_in low mid-drain clears tx_valid the same cycle.
